// File: rtl/argmax_classifier.sv
// Argmax over NUM_CLASSES buffered scores, one class per cycle, with sign-clamped compare.
// Optional runner-up / margin tracking is enabled by defining ARGMAX_MARGIN_EN.
module argmax_classifier #(
    parameter int                 NUM_CLASSES = 10,
    parameter int                 SCORE_W     = 8,
    parameter logic [SCORE_W-1:0] MARGIN_TH   = 8'h04
) (
    input  logic                           clk,
    input  logic                           iRst_n,
    input  logic                           ena,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     digit,
    output logic [SCORE_W-1:0]             max_score,
    output logic [SCORE_W-1:0]             margin,
    output logic                           low_conf
);

    localparam int              IDX_W    = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Negative (sign-bit set) scores count as zero.
    function automatic logic [SCORE_W-1:0] eff_f(input logic [SCORE_W-1:0] s);
        return s[SCORE_W-1] ? {SCORE_W{1'b0}} : s;
    endfunction

    state_e                           state_q, state_d;
    logic [NUM_CLASSES*SCORE_W-1:0]   buf_q, buf_d;
    logic [SCORE_W-1:0]               best_q, best_d;
    logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                 cnt_q, cnt_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [IDX_W-1:0]                 digit_q, digit_d;
    logic [SCORE_W-1:0]               max_q, max_d;

    logic [SCORE_W-1:0]               cand_s;
    logic                             take_s;
    logic [SCORE_W-1:0]               new_best_s;
    logic [IDX_W-1:0]                 new_idx_s;

    assign cand_s     = eff_f(buf_q[cnt_q*SCORE_W +: SCORE_W]);
    assign take_s     = cand_s > best_q;
    assign new_best_s = take_s ? cand_s : best_q;
    assign new_idx_s  = take_s ? cnt_q : best_idx_q;

`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W-1:0]               second_q, second_d;
    logic [SCORE_W-1:0]               margin_q, margin_d;
    logic                             low_conf_q, low_conf_d;
    logic [SCORE_W-1:0]               new_second_s;
    logic [SCORE_W-1:0]               gap_s;

    // A displaced best becomes the runner-up; otherwise the runner-up only grows.
    assign new_second_s = take_s ? best_q : ((cand_s > second_q) ? cand_s : second_q);
    assign gap_s        = new_best_s - new_second_s;
`endif

    // State machine next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        digit_d    = digit_q;
        max_d      = max_q;
`ifdef ARGMAX_MARGIN_EN
        second_d   = second_q;
        margin_d   = margin_q;
        low_conf_d = low_conf_q;
`endif
        if (!ena) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        buf_d      = scores;
                        best_d     = eff_f(scores[SCORE_W-1:0]);
                        best_idx_d = {IDX_W{1'b0}};
                        cnt_d      = {{(IDX_W-1){1'b0}}, 1'b1};
                        done_d     = 1'b0;
                        busy_d     = 1'b1;
`ifdef ARGMAX_MARGIN_EN
                        second_d   = {SCORE_W{1'b0}};
`endif
                        state_d    = SCAN;
                    end else begin
                        state_d = state_q;
                    end
                end
                SCAN: begin
                    best_d     = new_best_s;
                    best_idx_d = new_idx_s;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = new_second_s;
`endif
                    if (cnt_q == LAST_IDX) begin
                        digit_d = new_idx_s;
                        max_d   = new_best_s;
`ifdef ARGMAX_MARGIN_EN
                        margin_d   = gap_s;
                        low_conf_d = gap_s < MARGIN_TH;
`endif
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any partial scan.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            buf_q      <= {(NUM_CLASSES*SCORE_W){1'b0}};
            best_q     <= {SCORE_W{1'b0}};
            best_idx_q <= {IDX_W{1'b0}};
            cnt_q      <= {IDX_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= {IDX_W{1'b0}};
            max_q      <= {SCORE_W{1'b0}};
`ifdef ARGMAX_MARGIN_EN
            second_q   <= {SCORE_W{1'b0}};
            margin_q   <= {SCORE_W{1'b0}};
            low_conf_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            digit_q    <= digit_d;
            max_q      <= max_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
            margin_q   <= margin_d;
            low_conf_q <= low_conf_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign digit     = digit_q;
    assign max_score = max_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin    = margin_q;
    assign low_conf  = low_conf_q;
`else
    assign margin    = {SCORE_W{1'b0}};
    assign low_conf  = 1'b0;
`endif

endmodule
